// File: rtl/dmem_waitstate.sv
`default_nettype none
// ============================================================================
// Module   : dmem_waitstate
// Brief    : Multi-cycle data memory for the MEM stage with programmable wait
//            states, ready handshake, byte lanes and out-of-range detection.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_waitstate #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3,
    parameter int RESET_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_res,
    input  logic [DATA_W-1:0] Val_Rm,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    input  logic              byte_mode,
    output logic [DATA_W-1:0] res_data,
    output logic              ready,
    output logic              addr_err
);

    localparam int          c_AW    = $clog2(DEPTH);
    localparam int          c_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0] c_BASE  = 32'(BASE_ADDR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic              w_commit;

    logic              w_req;
    logic [29:0]       w_idx_full;
    logic [c_AW-1:0]   w_idx;
    logic [1:0]        w_lane;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_rd_result;

    assign w_req      = mem_r_en | mem_w_en;
    // Word index of the wrapped offset from the base address
    assign w_idx_full = 30'((alu_res - c_BASE) >> 2);
    assign w_idx      = w_idx_full[c_AW-1:0];
    assign w_lane     = alu_res[1:0];
    assign w_in_range = (alu_res >= c_BASE) && ({2'b00, w_idx_full} < 32'(DEPTH));
    assign w_rdata    = r_mem[w_idx];

    always_comb begin
        w_rd_result = '0;
        if (w_in_range) begin
            if (byte_mode) begin
                w_rd_result = DATA_W'(w_rdata[8*w_lane +: 8]);
            end else begin
                w_rd_result = w_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_DONE;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            res_data <= '0;
            ready    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            ready    <= w_commit;
            addr_err <= w_commit & ~w_in_range;
            // A simultaneous read+write is treated as a write only
            if (w_commit && mem_r_en && !mem_w_en) begin
                res_data <= w_rd_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_CLEAR != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end
        end else if (w_commit && mem_w_en && w_in_range) begin
            if (byte_mode) begin
                r_mem[w_idx][8*w_lane +: 8] <= Val_Rm[7:0];
            end else begin
                r_mem[w_idx] <= Val_Rm;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_waitstate.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_waitstate
// Brief    : Directed self-checking bench for dmem_waitstate (3 and 0 waits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_waitstate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_res = '0;
    logic [31:0] Val_Rm = '0;
    logic        mem_w_en = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        byte_mode = 1'b0;

    logic [31:0] res_a, res_b;
    logic        rdy_a, rdy_b, err_a, err_b;
    bit          sel = 1'b0;
    int          checks = 0;
    int          errors = 0;

    wire [31:0] obs_res = sel ? res_b : res_a;
    wire        obs_rdy = sel ? rdy_b : rdy_a;
    wire        obs_err = sel ? err_b : err_a;

    always #5 clk = ~clk;

    dmem_waitstate #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3), .RESET_CLEAR(1)) dut_w3 (
        .clk(clk), .rst(rst), .alu_res(alu_res), .Val_Rm(Val_Rm), .mem_w_en(mem_w_en),
        .mem_r_en(mem_r_en), .byte_mode(byte_mode), .res_data(res_a), .ready(rdy_a), .addr_err(err_a));

    dmem_waitstate #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0), .RESET_CLEAR(1)) dut_w0 (
        .clk(clk), .rst(rst), .alu_res(alu_res), .Val_Rm(Val_Rm), .mem_w_en(mem_w_en),
        .mem_r_en(mem_r_en), .byte_mode(byte_mode), .res_data(res_b), .ready(rdy_b), .addr_err(err_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access on the selected DUT; returns edges until ready was seen
    task automatic access(input bit we, input bit re, input bit bm, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rd, output logic err,
                          output int lat);
        alu_res = addr; Val_Rm = data; byte_mode = bm; mem_w_en = we; mem_r_en = re;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (obs_rdy !== 1'b1 && lat < 20);
        if (obs_rdy !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready_timeout addr=%0d: no ready within %0d cycles", addr, lat);
        end
        rd = obs_res; err = obs_err;
        mem_w_en = 1'b0; mem_r_en = 1'b0; byte_mode = 1'b0;
        tick();
        checks++;
        if (obs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ready_pulse_width addr=%0d: ready=%b required 0", addr, obs_rdy);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int lat;
        sel = 1'b0;
        rst = 1'b1; tick(); tick();
        checks++;
        if (obs_res !== 32'h0 || obs_rdy !== 1'b0 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: res=%h rdy=%b err=%b required 0/0/0", obs_res, obs_rdy, obs_err);
        end
        rst = 1'b0;
        access(1, 0, 0, 32'd1024, 32'hDEADBEEF, rd, err, lat);
        access(0, 1, 0, 32'd1024, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pre_reset_read: got %h required deadbeef", rd);
        end
        rst = 1'b1; tick();
        checks++;
        if (obs_res !== 32'h0 || obs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL during_reset: res=%h rdy=%b required 0/0", obs_res, obs_rdy);
        end
        rst = 1'b0;
        access(0, 1, 0, 32'd1024, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear: got %h err=%b required 0 err=0", rd, err);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic err; int lat;
        sel = 1'b0;
        access(1, 0, 0, 32'd1028, 32'h12345678, rd, err, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL write_latency: got %0d required 4", lat);
        end
        access(0, 1, 0, 32'd1028, 32'h0, rd, err, lat);
        checks++;
        if (lat != 4 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL read_latency: lat=%0d data=%h required 4 12345678", lat, rd);
        end
        access(0, 1, 0, 32'd1031, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL word_alignment: got %h required 12345678", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic err; int lat;
        sel = 1'b0;
        access(1, 0, 0, 32'd1032, 32'h11223344, rd, err, lat);
        access(1, 0, 1, 32'd1033, 32'hFFFFFFAA, rd, err, lat);
        access(0, 1, 0, 32'd1032, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h1122AA44) begin
            errors++;
            $display("FAIL byte_write: got %h required 1122aa44", rd);
        end
        access(0, 1, 1, 32'd1035, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h00000011) begin
            errors++;
            $display("FAIL byte_read: got %h required 00000011", rd);
        end
        access(0, 1, 1, 32'd1032, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h00000044) begin
            errors++;
            $display("FAIL byte_read_lane0: got %h required 00000044", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic err; int lat;
        sel = 1'b0;
        access(1, 0, 0, 32'd1024, 32'hCAFE0000, rd, err, lat);
        access(1, 0, 0, 32'd1276, 32'h0BAD0063, rd, err, lat);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL last_word_in_range: err=%b required 0", err);
        end
        access(1, 0, 0, 32'd1020, 32'h99999999, rd, err, lat);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL below_base_err: err=%b required 1", err);
        end
        access(1, 0, 0, 32'd1280, 32'h88888888, rd, err, lat);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL above_top_err: err=%b required 1", err);
        end
        access(0, 1, 0, 32'd1024, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hCAFE0000) begin
            errors++;
            $display("FAIL word0_unchanged: got %h required cafe0000", rd);
        end
        access(0, 1, 0, 32'd1276, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0BAD0063) begin
            errors++;
            $display("FAIL last_word_unchanged: got %h required 0bad0063", rd);
        end
        access(0, 1, 0, 32'd1020, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got %h err=%b required 0 err=1", rd, err);
        end
    endtask

    task automatic test_abort_and_reset();
        logic [31:0] rd; logic err; int lat;
        sel = 1'b0;
        alu_res = 32'd1036; Val_Rm = 32'hFFFFFFFF; byte_mode = 1'b0; mem_w_en = 1'b1;
        tick(); tick(); tick();
        mem_w_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_rdy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_ready cycle %0d: ready=%b required 0", i, obs_rdy);
            end
        end
        access(0, 1, 0, 32'd1036, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_write: got %h required 0", rd);
        end
        alu_res = 32'd1036; Val_Rm = 32'h55555555; mem_w_en = 1'b1;
        tick(); tick();
        rst = 1'b1; mem_w_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_rdy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort_no_ready cycle %0d: ready=%b required 0", i, obs_rdy);
            end
        end
        access(0, 1, 0, 32'd1036, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || lat != 4) begin
            errors++;
            $display("FAIL reset_abort_idle: data=%h lat=%0d required 0 lat 4", rd, lat);
        end
    endtask

    task automatic test_wait0_simultaneous();
        logic [31:0] rd; logic err; int lat;
        sel = 1'b1;
        access(1, 0, 0, 32'd1040, 32'h01020304, rd, err, lat);
        access(0, 1, 0, 32'd1040, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h01020304 || lat != 1) begin
            errors++;
            $display("FAIL w0_read: data=%h lat=%0d required 01020304 lat 1", rd, lat);
        end
        access(1, 1, 0, 32'd1040, 32'h5A5A5A5A, rd, err, lat);
        checks++;
        if (lat != 1 || rd !== 32'h01020304) begin
            errors++;
            $display("FAIL w0_simul: lat=%0d res=%h required lat 1 res 01020304", lat, rd);
        end
        access(0, 1, 0, 32'd1040, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL w0_simul_written: got %h required 5a5a5a5a", rd);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_byte_lanes();
        test_out_of_range();
        test_abort_and_reset();
        test_wait0_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
